// File: rtl/trig_scheduler_pkg.sv
// Shared fixed-point format, trig constants and FSM state type for trig_scheduler.
// Angles are signed radians with FLOAT_DCM_BITS fraction bits.
package trig_scheduler_pkg;

   localparam int FLOAT_BITS     = 24;
   localparam int FLOAT_DCM_BITS = 16;

   typedef logic signed [FLOAT_BITS-1:0] fx_t;
   typedef logic signed [FLOAT_BITS:0]   fx_wide_t;
   typedef logic signed [2*FLOAT_BITS-1:0] fx_prod_t;

   localparam fx_t PI          = 24'sd205887;
   localparam fx_t NEG_PI      = -24'sd205887;
   localparam fx_t HALF_PI     = 24'sd102944;
   localparam fx_t NEG_HALF_PI = -24'sd102944;
   localparam fx_t TWO_PI      = 24'sd411775;
   localparam fx_t INV_6       = 24'sd10923;
   localparam fx_t INV_120     = 24'sd546;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REDUCE,
      S_SIN,
      S_COS,
      S_DONE
   } trig_state_t;

   // Sums are formed one bit wider, then truncated back to the angle format.
   function automatic fx_t fx_add(input fx_t a, input fx_t b);
      fx_wide_t s;
      s = fx_wide_t'(a) + fx_wide_t'(b);
      return fx_t'(s);
   endfunction

   function automatic fx_t fx_sub(input fx_t a, input fx_t b);
      fx_wide_t s;
      s = fx_wide_t'(a) - fx_wide_t'(b);
      return fx_t'(s);
   endfunction

   function automatic fx_t fx_mul(input fx_t a, input fx_t b);
      fx_prod_t p;
      p = a * b;
      return fx_t'(p >>> FLOAT_DCM_BITS);
   endfunction

endpackage

// File: rtl/trig_scheduler_if.sv
// Request/response bus between requesters, the result consumer and trig_scheduler.
interface trig_scheduler_if
   import trig_scheduler_pkg::*;
#(
   parameter int N_REQ = 4
) ();

   localparam int IDW = $clog2(N_REQ);

   // A transfer happens on a clock edge where valid and ready are both high;
   // valid may drop before ready, payload is only sampled at the transfer edge.
   logic [N_REQ-1:0]      req_valid;
   fx_t  [N_REQ-1:0]      req_angle;
   logic [N_REQ-1:0]      req_ready;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   fx_t                   rsp_sin;
   fx_t                   rsp_cos;
   logic                  rsp_err;

   modport master (
      output req_valid, req_angle, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sin, rsp_cos, rsp_err
   );

   modport slave (
      input  req_valid, req_angle, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sin, rsp_cos, rsp_err
   );

endinterface

// File: rtl/trig_scheduler_fold.sv
// angle_fold: maps an angle in [-pi, pi] into [-pi/2, pi/2] preserving its sine.
// trig_sin: shared combinational odd-polynomial sine, valid on [-pi/2, pi/2].
module angle_fold
   import trig_scheduler_pkg::*;
(
   input  fx_t i_v,
   output fx_t o_f
);

   always_comb begin
      if (i_v > HALF_PI)
         o_f = fx_sub(PI, i_v);
      else if (i_v < NEG_HALF_PI)
         o_f = fx_sub(NEG_PI, i_v);
      else
         o_f = i_v;
   end

endmodule

module trig_sin
   import trig_scheduler_pkg::*;
(
   input  fx_t i_x,
   output fx_t o_y
);

   fx_t w_x2;
   fx_t w_x3;
   fx_t w_x5;
   fx_t w_t3;
   fx_t w_t5;

   // x - x^3/6 + x^5/120
   assign w_x2 = fx_mul(i_x, i_x);
   assign w_x3 = fx_mul(w_x2, i_x);
   assign w_x5 = fx_mul(w_x3, w_x2);
   assign w_t3 = fx_mul(w_x3, INV_6);
   assign w_t5 = fx_mul(w_x5, INV_120);
   assign o_y  = fx_add(fx_sub(i_x, w_t3), w_t5);

endmodule

// File: rtl/trig_scheduler.sv
// Round-robin scheduler sharing one sine evaluator among N_REQ requesters;
// each job reduces the angle, then evaluates sin and cos on the same evaluator.
module trig_scheduler
   import trig_scheduler_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int MAX_WRAP = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   trig_scheduler_if.slave bus,
   output logic        busy,
   output trig_state_t o_dbg_state
);

   localparam int IDW = $clog2(N_REQ);
   localparam int WW  = $clog2(MAX_WRAP + 1);

   trig_state_t    r_state;
   logic [IDW-1:0] r_rr;
   logic [IDW-1:0] r_id;
   logic [WW-1:0]  r_wrap;
   fx_t            r_x;
   fx_t            r_sin;
   fx_t            r_cos;
   logic           r_err;

   logic           w_gnt_vld;
   logic [IDW-1:0] w_gnt_idx;
   logic [IDW-1:0] w_rr_next;
   logic           w_hi;
   logic           w_lo;
   fx_t            w_x_dec;
   fx_t            w_x_inc;
   fx_t            w_c_raw;
   fx_t            w_c;
   fx_t            w_fold_x;
   fx_t            w_fold_c;
   fx_t            w_eval_in;
   fx_t            w_eval_out;

   // First valid requester at or after the round-robin pointer.
   always_comb begin
      int             j;
      logic [IDW-1:0] idx;
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      j         = 0;
      idx       = '0;
      for (int k = 0; k < N_REQ; k++) begin
         j = int'(r_rr) + k;
         if (j >= N_REQ)
            j = j - N_REQ;
         idx = IDW'(j);
         if (!w_gnt_vld && bus.req_valid[idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = idx;
         end
      end
   end

   assign w_rr_next = (w_gnt_idx == IDW'(N_REQ - 1)) ? '0 : w_gnt_idx + IDW'(1);

   assign bus.req_ready = (rst_n && r_state == S_IDLE && w_gnt_vld)
                          ? (N_REQ'(1) << w_gnt_idx) : '0;

   assign w_hi    = r_x > PI;
   assign w_lo    = r_x < NEG_PI;
   assign w_x_dec = fx_sub(r_x, TWO_PI);
   assign w_x_inc = fx_add(r_x, TWO_PI);

   // cos(x) = sin(x + pi/2), rewrapped into [-pi, pi] before folding.
   assign w_c_raw = fx_add(r_x, HALF_PI);
   assign w_c     = (w_c_raw > PI) ? fx_sub(w_c_raw, TWO_PI) : w_c_raw;

   angle_fold u_fold_sin (.i_v(r_x), .o_f(w_fold_x));
   angle_fold u_fold_cos (.i_v(w_c), .o_f(w_fold_c));

   always_comb begin
      case (r_state)
         S_SIN:   w_eval_in = w_fold_x;
         S_COS:   w_eval_in = w_fold_c;
         default: w_eval_in = '0;
      endcase
   end

   trig_sin u_sin (.i_x(w_eval_in), .o_y(w_eval_out));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_rr    <= '0;
         r_id    <= '0;
         r_wrap  <= '0;
         r_x     <= '0;
         r_sin   <= '0;
         r_cos   <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt_vld) begin
                  r_x     <= bus.req_angle[w_gnt_idx];
                  r_id    <= w_gnt_idx;
                  r_wrap  <= '0;
                  r_rr    <= w_rr_next;
                  r_state <= S_REDUCE;
               end
            end
            S_REDUCE: begin
               if (w_hi || w_lo) begin
                  if (r_wrap == WW'(MAX_WRAP)) begin
                     r_err   <= 1'b1;
                     r_sin   <= '0;
                     r_cos   <= '0;
                     r_state <= S_DONE;
                  end else begin
                     r_x    <= w_hi ? w_x_dec : w_x_inc;
                     r_wrap <= r_wrap + WW'(1);
                  end
               end else begin
                  r_state <= S_SIN;
               end
            end
            S_SIN: begin
               r_sin   <= w_eval_out;
               r_state <= S_COS;
            end
            S_COS: begin
               r_cos   <= w_eval_out;
               r_state <= S_DONE;
            end
            S_DONE: begin
               if (bus.rsp_ready) begin
                  r_err   <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.rsp_valid = (r_state == S_DONE);
   assign bus.rsp_id    = r_id;
   assign bus.rsp_sin   = r_sin;
   assign bus.rsp_cos   = r_cos;
   assign bus.rsp_err   = r_err;
   assign busy          = (r_state != S_IDLE);
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_trig_scheduler.sv
// Bench for trig_scheduler: transaction-level model (grant order, latency from
// wrap count, sin/cos from real math) checked every cycle, plus directed cases.
module tb_trig_scheduler;
   import trig_scheduler_pkg::*;

   localparam int     N         = 4;
   localparam int     MAXW      = 8;
   localparam longint FX_PI     = 205887;
   localparam longint FX_HALF   = 102944;
   localparam longint FX_TWO_PI = 411775;
   localparam real    SCALE     = 65536.0;
   localparam real    TOL       = 0.005;

   typedef struct {
      int  id;
      bit  err;
      real s;
      real c;
   } exp_t;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst_n;
   logic        busy;
   trig_state_t dbg_state;

   trig_scheduler_if #(.N_REQ(N)) bus ();

   trig_scheduler #(.N_REQ(N), .MAX_WRAP(MAXW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .busy        (busy),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];
   bit   m_busy   = 1'b0;
   bit   m_done   = 1'b0;
   int   m_cnt    = 0;
   int   m_rr     = 0;
   int   cyc      = 0;
   bit   chk_en   = 1'b0;
   bit   rec_en   = 1'b0;
   int   gnt_id_q[$];
   int   gnt_cyc_q[$];

   task automatic check_int(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_real(input string name, input real act, input real exp, input real tol);
      real d;
      n_checks++;
      d = act - exp;
      if (d < 0.0) d = -d;
      if (d > tol) begin
         n_fail++;
         $display("FAIL %s: got %f expected %f tol %f (t=%0t)", name, act, exp, tol, $time);
      end
   endtask

   function automatic real to_real(input fx_t v);
      return real'(v) / SCALE;
   endfunction

   function automatic bit exp_grant(input logic [N-1:0] v, input int rr, output int g);
      g = 0;
      for (int k = 0; k < N; k++) begin
         if (v[(rr + k) % N]) begin
            g = (rr + k) % N;
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   // Job outcome from the angle alone: wrap count decides latency/error, values from real math.
   task automatic model_job(input longint ang, output int lat, output exp_t e);
      longint v;
      int     k;
      bit     err;
      v   = ang;
      k   = 0;
      err = 1'b0;
      while (v > FX_PI || v < -FX_PI) begin
         if (k == MAXW) begin
            err = 1'b1;
            break;
         end
         if (v > FX_PI) v = v - FX_TWO_PI;
         else           v = v + FX_TWO_PI;
         k++;
      end
      lat   = err ? MAXW + 1 : k + 3;
      e.id  = 0;
      e.err = err;
      e.s   = err ? 0.0 : $sin(real'(ang) / SCALE);
      e.c   = err ? 0.0 : $cos(real'(ang) / SCALE);
   endtask

   // Model advance on every active edge.
   initial begin
      int   mg;
      int   mlat;
      exp_t me;
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_rr   = 0;
            exp_q.delete();
         end else if (m_done) begin
            if (bus.rsp_ready) begin
               m_done = 1'b0;
               m_busy = 1'b0;
               void'(exp_q.pop_front());
            end
         end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) m_done = 1'b1;
         end else if (exp_grant(bus.req_valid, m_rr, mg)) begin
            model_job(longint'(bus.req_angle[mg]), mlat, me);
            me.id = mg;
            exp_q.push_back(me);
            m_busy = 1'b1;
            m_cnt  = mlat;
            m_rr   = (mg + 1) % N;
         end
      end
   end

   // Compare process: outputs sampled on the falling edge.
   initial begin
      int         cg;
      logic [N-1:0] exp_rdy;
      exp_t       ce;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            exp_rdy = '0;
            if (rst_n && !m_busy && exp_grant(bus.req_valid, m_rr, cg)) exp_rdy[cg] = 1'b1;
            check_int("req_ready", bus.req_ready, exp_rdy);
            check_int("busy", busy, m_busy);
            check_int("rsp_valid", bus.rsp_valid, m_done);
            if (m_done && exp_q.size() > 0) begin
               ce = exp_q[0];
               check_int("rsp_id", bus.rsp_id, ce.id);
               check_int("rsp_err", bus.rsp_err, ce.err);
               if (ce.err) begin
                  check_int("rsp_sin_err", bus.rsp_sin, 0);
                  check_int("rsp_cos_err", bus.rsp_cos, 0);
               end else begin
                  check_real("rsp_sin", to_real(bus.rsp_sin), ce.s, TOL);
                  check_real("rsp_cos", to_real(bus.rsp_cos), ce.c, TOL);
               end
            end
            if (rec_en && bus.req_ready != '0) begin
               for (int k = 0; k < N; k++) begin
                  if (bus.req_ready[k]) begin
                     gnt_id_q.push_back(k);
                     gnt_cyc_q.push_back(cyc);
                  end
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic reset_checks(input string tag);
      check_int({tag, "_rsp_valid"}, bus.rsp_valid, 0);
      check_int({tag, "_req_ready"}, bus.req_ready, 0);
      check_int({tag, "_rsp_id"},    bus.rsp_id, 0);
      check_int({tag, "_rsp_sin"},   bus.rsp_sin, 0);
      check_int({tag, "_rsp_cos"},   bus.rsp_cos, 0);
      check_int({tag, "_rsp_err"},   bus.rsp_err, 0);
      check_int({tag, "_busy"},      busy, 0);
      check_int({tag, "_state"},     dbg_state, S_IDLE);
   endtask

   // Issue one request as the only valid requester; return grant-to-response latency.
   task automatic run_job(input int id, input fx_t ang, output int lat);
      bit got;
      bit done;
      got  = 1'b0;
      done = 1'b0;
      lat  = 0;
      @(posedge clk); #1;
      bus.req_angle[id] = ang;
      bus.req_valid     = N'(1) << id;
      for (int c = 0; c < 30 && !got; c++) begin
         @(negedge clk);
         if (bus.req_ready[id]) got = 1'b1;
      end
      check_int("grant_seen", got, 1);
      if (got) check_int("grant_onehot", bus.req_ready, longint'(N'(1) << id));
      @(posedge clk); #1;
      bus.req_valid = '0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (bus.rsp_valid) done = 1'b1;
      end
      check_int("rsp_seen", done, 1);
   endtask

   function automatic fx_t rand_angle();
      int  s;
      fx_t r;
      s = $urandom_range(0, 9);
      if (s < 6) begin
         r = fx_t'(int'($urandom_range(0, 1647100)) - 823550);
      end else if (s < 8) begin
         case ($urandom_range(0, 7))
            0:       r = fx_t'(FX_PI);
            1:       r = fx_t'(-FX_PI);
            2:       r = fx_t'(FX_HALF);
            3:       r = fx_t'(-FX_HALF);
            4:       r = fx_t'(FX_PI + 1);
            5:       r = fx_t'(-FX_PI - 1);
            6:       r = fx_t'(FX_HALF + 1);
            default: r = '0;
         endcase
      end else begin
         r = fx_t'($urandom);
      end
      return r;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int  lat;
      bit  got;
      int  w;
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) bus.req_angle[i] = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      reset_checks("por");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // angle 0 on requester 1
      run_job(1, fx_t'(0), lat);
      check_int("zero_latency", lat, 3);
      check_int("zero_id", bus.rsp_id, 1);
      check_int("zero_err", bus.rsp_err, 0);
      check_real("zero_sin", to_real(bus.rsp_sin), 0.0, TOL);
      check_real("zero_cos", to_real(bus.rsp_cos), 1.0, TOL);

      // 2.5 rad exercises both folds
      run_job(2, fx_t'(163840), lat);
      check_int("fold_latency", lat, 3);
      check_real("fold_sin", to_real(bus.rsp_sin), 0.5985, TOL);
      check_real("fold_cos", to_real(bus.rsp_cos), -0.8011, TOL);

      // 10.0 rad needs two wraps
      run_job(3, fx_t'(655360), lat);
      check_int("wrap_latency", lat, 5);
      check_real("wrap_sin", to_real(bus.rsp_sin), -0.5440, TOL);
      check_real("wrap_cos", to_real(bus.rsp_cos), -0.8391, TOL);

      // max positive angle cannot converge
      run_job(0, fx_t'(24'h7FFFFF), lat);
      check_int("err_latency", lat, MAXW + 1);
      check_int("err_flag", bus.rsp_err, 1);
      check_int("err_sin", bus.rsp_sin, 0);
      check_int("err_cos", bus.rsp_cos, 0);

      // backpressure: DONE held for 10 cycles with every requester waiting
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      run_job(1, fx_t'(65536), lat);
      @(posedge clk); #1;
      bus.req_valid = '1;
      repeat (10) @(negedge clk);
      check_int("bp_rsp_valid", bus.rsp_valid, 1);
      check_int("bp_req_ready", bus.req_ready, 0);
      check_int("bp_rsp_id", bus.rsp_id, 1);
      check_real("bp_sin", to_real(bus.rsp_sin), 0.8415, TOL);
      check_real("bp_cos", to_real(bus.rsp_cos), 0.5403, TOL);
      @(posedge clk); #1;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      repeat (2) @(posedge clk);

      // reset during REDUCE abandons the job
      #1;
      bus.req_angle[2] = fx_t'(655360);
      bus.req_valid    = 4'b0100;
      got = 1'b0;
      for (int c = 0; c < 30 && !got; c++) begin
         @(negedge clk);
         if (bus.req_ready[2]) got = 1'b1;
      end
      check_int("mid_grant_seen", got, 1);
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_checks("mid_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // round robin with everyone requesting
      for (int i = 0; i < N; i++) bus.req_angle[i] = fx_t'(int'($urandom_range(0, 411774)) - 205887);
      rec_en        = 1'b1;
      bus.req_valid = '1;
      w = 0;
      while (gnt_id_q.size() < 8 && w < 100) begin
         @(posedge clk);
         w++;
      end
      #1;
      rec_en        = 1'b0;
      bus.req_valid = '0;
      check_int("rr_grant_count", gnt_id_q.size() >= 8, 1);
      for (int i = 0; i < 8 && i < gnt_id_q.size(); i++) begin
         check_int($sformatf("rr_order_%0d", i), gnt_id_q[i], i % N);
         if (i > 0) check_int($sformatf("rr_spacing_%0d", i), gnt_cyc_q[i] - gnt_cyc_q[i-1], 5);
      end

      // randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         bus.req_valid = N'($urandom_range(0, 15));
         for (int i = 0; i < N; i++) bus.req_angle[i] = rand_angle();
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check_int("drain_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/trig_scheduler.md
# trig_scheduler

Shares one combinational `sin` evaluator between `N_REQ` requesters. It runs a multi-cycle job per request: angle range reduction, a sine evaluation, then a cosine evaluation through the same evaluator. Tangram pose and rotation logic uses it to turn piece angles into `sin`/`cos` pairs without instantiating one evaluator per consumer.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (≥2)
- `MAX_WRAP`, 8, maximum ±2π correction steps before an error is flagged

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous, active-low reset
- `req_valid`  in  N_REQ  per-requester request strobe
- `req_angle`  in  N_REQ×`FLOAT_BITS`  signed fixed-point angle, radians, `FLOAT_DCM_BITS` fraction bits
- `req_ready`  out  N_REQ  one-hot grant; handshake completes when `req_valid[i] & req_ready[i]`
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer accepts the result
- `rsp_id`  out  `$clog2(N_REQ)`  index of the served requester
- `rsp_sin`  out  `FLOAT_BITS`  sine of the angle
- `rsp_cos`  out  `FLOAT_BITS`  cosine of the angle
- `rsp_err`  out  1  reduction did not converge; `rsp_sin` and `rsp_cos` are 0
- `busy`  out  1  state ≠ IDLE

## Operation
- The FSM states are IDLE, REDUCE, SIN, COS and DONE.
- **IDLE:**
  - Round-robin arbitration starts at pointer `rr`.
  - `req_ready` is asserted combinationally for the first valid requester at or after `rr`. All other `req_ready` bits are 0.
  - On grant: `x ← req_angle[g]`, `id ← g`, `wrap_cnt ← 0`, `rr ← g+1` (modulo N_REQ), next state REDUCE.
  - With no valid requester, the FSM stays in IDLE.
- **REDUCE:** one step per cycle.
  - If `x > PI`: `x ← x − TWO_PI` and `wrap_cnt++`.
  - Else if `x < −PI`: `x ← x + TWO_PI` and `wrap_cnt++`.
  - Else next state is SIN.
  - If `wrap_cnt == MAX_WRAP` and `x` is still out of range: `err ← 1`, `sin_r ← 0`, `cos_r ← 0`, next state DONE.
- **SIN:**
  - `f ← fold(x)`, where fold maps `v > HALF_PI` to `PI − v` and `v < −HALF_PI` to `−PI − v`. Otherwise `v` is unchanged.
  - Drive the evaluator with `f` and register `sin_r ← sin(f)`. Next state COS.
- **COS:**
  - `c = x + HALF_PI`; if `c > PI`, `c ← c − TWO_PI`.
  - Drive the evaluator with `fold(c)` and register `cos_r`. Next state DONE.
- **DONE:**
  - `rsp_valid = 1`; `rsp_id`, `rsp_sin`, `rsp_cos` and `rsp_err` are held stable.
  - On `rsp_ready`: `err ← 0`, next state IDLE.
- Exactly one evaluator instance exists. Its input is muxed by state and is 0 outside SIN and COS.
- All additions and subtractions are done at `FLOAT_BITS + 1` bits and then truncated. This is safe because reduced values satisfy `|x| ≤ PI + HALF_PI`.

## Timing
- **Reset** (`rst_n=0` at a clock edge):
  - state IDLE, `rr=0`, `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_sin=0`, `rsp_cos=0`, `rsp_err=0`, `busy=0`.
  - Reset mid-job abandons the job with no response.
  - The requester must re-issue the request; `req_ready` was already consumed.
- **Latency:** grant edge to `rsp_valid=1` is `k+3` cycles, where `k` is the number of wrap steps (0…MAX_WRAP). An in-range angle takes 3 cycles.
  - Error path: `MAX_WRAP+1` cycles.
- **Throughput:**
  - One job in flight.
  - `rsp_ready` held high in DONE gives IDLE on the next cycle and a new grant in that IDLE cycle.
  - Minimum request spacing is therefore 5 cycles.
- **Arbitration rules:**
  - `req_ready` is never asserted outside IDLE.
  - A requester dropping `req_valid` before its grant is legal.
  - `req_angle` is sampled only on the grant edge.
- **Backpressure:** `rsp_ready=0` holds DONE indefinitely with outputs stable.
- **Boundary cases:**
  - `x == PI` or `x == −PI` counts as in range.
  - `x == HALF_PI` is not folded.

## Structure
- `constants.h` gains `PI`, `HALF_PI` and `TWO_PI` in the existing `FLOAT_BITS`/`FLOAT_DCM_BITS` fixed-point format, alongside `INV_6` and `INV_120`.
- `trig_pkg` holds the FSM state enum `trig_state_t`.
- Sub-module `angle_fold`: combinational fold into [−π/2, π/2]. It is instantiated twice: for the SIN input and for the COS input.
- The sine evaluator is the existing `sin` module, instantiated once.

## Test plan
- Reset, then `req_valid[1]=1` with angle 0 → `req_ready=0010` in IDLE; 3 cycles later `rsp_valid=1`, `rsp_id=1`, sin=0, cos within 0.005 of 1.0, `rsp_err=0`.
- Angle 2.5 rad → fold path taken; sin within 0.005 of 0.5985, cos within 0.005 of −0.8011.
- Angle 10.0 rad → 2 wrap steps, latency 5 cycles; sin within 0.005 of −0.5440, cos within 0.005 of −0.8391.
- Angle near max positive (beyond `MAX_WRAP`·2π) → `rsp_err=1`, sin=cos=0 after `MAX_WRAP+1` cycles.
- All four `req_valid` held high over 8 jobs, `rsp_ready=1` → grant order 0,1,2,3,0,1,2,3; exactly one `req_ready` bit per IDLE cycle; spacing 5 cycles.
- Remaining cases:
  - `rsp_ready=0` for 10 cycles in DONE → outputs stable and no new grant.
  - Reset asserted during REDUCE → all outputs return to reset values the next cycle.
